// File: rtl/parking_pkg.sv
// Shared types and 7-segment helpers for the parking occupancy block.
// Segments are active-low, bit0 = a .. bit6 = g.
package parking_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONFIRM,
        S_HELD
    } exit_state_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg7_decode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/parking_occupancy_ctrl_exit_debounce.sv
// Exit-lane sensor debouncer: one registered exit_evt pulse per
// sensor assertion lasting DEBOUNCE_CYC consecutive high samples.
module exit_debounce
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_exit,
    output logic exit_evt
);

    localparam logic [7:0] LAST_RUN = 8'(DEBOUNCE_CYC - 1);

    exit_state_t r_state;
    exit_state_t w_state_nxt;
    logic [7:0]  r_run;
    logic [7:0]  w_run_nxt;
    logic        r_evt;
    logic        w_evt_nxt;

    // FSM state, run counter and pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_run   <= 8'd0;
            r_evt   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            r_evt   <= w_evt_nxt;
        end
    end

    // Next-state: count consecutive highs, fire once, wait for release
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_evt_nxt   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_run_nxt = 8'd0;
                if (sensor_exit) begin
                    w_state_nxt = S_CONFIRM;
                    w_run_nxt   = 8'd1;
                end
            end
            S_CONFIRM: begin
                if (!sensor_exit) begin
                    w_state_nxt = S_IDLE;
                    w_run_nxt   = 8'd0;
                end else if (r_run == LAST_RUN) begin
                    w_state_nxt = S_HELD;
                    w_run_nxt   = 8'd0;
                    w_evt_nxt   = 1'b1;
                end else begin
                    w_run_nxt = r_run + 8'd1;
                end
            end
            S_HELD: begin
                w_run_nxt = 8'd0;
                if (!sensor_exit) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_run_nxt   = 8'd0;
            end
        endcase
    end

    assign exit_evt = r_evt;

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Lot occupancy counter with full/empty flags and free-slot display.
// Optional near-full flag enabled by defining OCC_NEAR_FULL_EN.
module parking_occupancy_ctrl
    import parking_pkg::*;
#(
    parameter int CAPACITY     = 20,
    parameter int DEBOUNCE_CYC = 4,
    parameter int CNT_W        = 7
`ifdef OCC_NEAR_FULL_EN
    ,
    parameter int NEAR_FULL_THRESH = CAPACITY - 2
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             car_admit,
    input  logic             sensor_exit,
    output logic [CNT_W-1:0] occupancy,
    output logic [CNT_W-1:0] free_slots,
    output logic             lot_full,
    output logic             lot_empty,
    output logic             exit_evt,
    output logic             err_flag,
    output logic             near_full,
    output logic [6:0]       hex_tens,
    output logic [6:0]       hex_ones
);

    localparam logic [CNT_W-1:0] CAP_C      = CNT_W'(CAPACITY);
    localparam logic             TENS_BLANK = (CAPACITY < 10);
    localparam logic [3:0]       CAP_TENS   = 4'(CAPACITY / 10);
    localparam logic [3:0]       CAP_ONES   = 4'(CAPACITY % 10);

    logic [CNT_W-1:0] r_occ;
    logic [CNT_W-1:0] r_free;
    logic             r_full;
    logic             r_empty;
    logic             r_err;
    logic [6:0]       r_hex_t;
    logic [6:0]       r_hex_o;

    logic             w_evt;
    logic [CNT_W-1:0] w_occ_nxt;
    logic             w_err_set;
    logic [3:0]       w_tens_bcd;
    logic [3:0]       w_ones_bcd;

    exit_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_exit_debounce (
        .clk        (clk),
        .reset      (reset),
        .sensor_exit(sensor_exit),
        .exit_evt   (w_evt)
    );

    // Saturating count update; simultaneous admit and exit cancel
    always_comb begin
        w_occ_nxt = r_occ;
        w_err_set = 1'b0;
        unique case ({car_admit, w_evt})
            2'b10: begin
                if (r_full) w_err_set = 1'b1;
                else        w_occ_nxt = r_occ + 1'b1;
            end
            2'b01: begin
                if (r_empty) w_err_set = 1'b1;
                else         w_occ_nxt = r_occ - 1'b1;
            end
            default: begin
                w_occ_nxt = r_occ;
            end
        endcase
    end

    // Occupancy and its derived flags registered together
    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ   <= '0;
            r_free  <= CAP_C;
            r_full  <= (CAP_C == '0);
            r_empty <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_occ   <= w_occ_nxt;
            r_free  <= CAP_C - w_occ_nxt;
            r_full  <= (w_occ_nxt == CAP_C);
            r_empty <= (w_occ_nxt == '0);
            r_err   <= r_err | w_err_set;
        end
    end

    assign w_tens_bcd = 4'(r_free / CNT_W'(10));
    assign w_ones_bcd = 4'(r_free % CNT_W'(10));

    // Display digits follow free_slots by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hex_t <= TENS_BLANK ? SEG_BLANK : seg7_decode(CAP_TENS);
            r_hex_o <= seg7_decode(CAP_ONES);
        end else begin
            r_hex_t <= TENS_BLANK ? SEG_BLANK : seg7_decode(w_tens_bcd);
            r_hex_o <= seg7_decode(w_ones_bcd);
        end
    end

`ifdef OCC_NEAR_FULL_EN
    localparam logic [CNT_W-1:0] NF_C = CNT_W'(NEAR_FULL_THRESH);

    logic r_near;

    // Near-full tracks the next occupancy, same cycle as the count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_near <= 1'b0;
        end else begin
            r_near <= (w_occ_nxt >= NF_C);
        end
    end

    assign near_full = r_near;
`else
    assign near_full = 1'b0;
`endif

    assign occupancy  = r_occ;
    assign free_slots = r_free;
    assign lot_full   = r_full;
    assign lot_empty  = r_empty;
    assign exit_evt   = w_evt;
    assign err_flag   = r_err;
    assign hex_tens   = r_hex_t;
    assign hex_ones   = r_hex_o;

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Directed bench for parking_occupancy_ctrl, CAPACITY=3, DEBOUNCE_CYC=4.
// Near-full expectations follow OCC_NEAR_FULL_EN.
module tb_parking_occupancy_ctrl;

    localparam int CNT_W = 7;

    localparam logic [6:0] E_SEG_0     = 7'h40;
    localparam logic [6:0] E_SEG_1     = 7'h79;
    localparam logic [6:0] E_SEG_2     = 7'h24;
    localparam logic [6:0] E_SEG_3     = 7'h30;
    localparam logic [6:0] E_SEG_BLANK = 7'h7F;

`ifdef OCC_NEAR_FULL_EN
    localparam bit NF_ON = 1'b1;
`else
    localparam bit NF_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             car_admit;
    logic             sensor_exit;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] free_slots;
    logic             lot_full;
    logic             lot_empty;
    logic             exit_evt;
    logic             err_flag;
    logic             near_full;
    logic [6:0]       hex_tens;
    logic [6:0]       hex_ones;

    int checks = 0;
    int errors = 0;
    int evt_cnt;
    int evt_idx;
    int occ_before;

    always #5 clk = ~clk;

    parking_occupancy_ctrl #(
        .CAPACITY    (3),
        .DEBOUNCE_CYC(4),
        .CNT_W       (CNT_W)
`ifdef OCC_NEAR_FULL_EN
        ,
        .NEAR_FULL_THRESH(2)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .car_admit  (car_admit),
        .sensor_exit(sensor_exit),
        .occupancy  (occupancy),
        .free_slots (free_slots),
        .lot_full   (lot_full),
        .lot_empty  (lot_empty),
        .exit_evt   (exit_evt),
        .err_flag   (err_flag),
        .near_full  (near_full),
        .hex_tens   (hex_tens),
        .hex_ones   (hex_ones)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_occ"},   32'(occupancy),  32'd0);
        chk({tag, "_free"},  32'(free_slots), 32'd3);
        chk({tag, "_full"},  32'(lot_full),   32'd0);
        chk({tag, "_empty"}, 32'(lot_empty),  32'd1);
        chk({tag, "_evt"},   32'(exit_evt),   32'd0);
        chk({tag, "_err"},   32'(err_flag),   32'd0);
        chk({tag, "_near"},  32'(near_full),  32'd0);
        chk({tag, "_htens"}, 32'(hex_tens),   32'(E_SEG_BLANK));
        chk({tag, "_hones"}, 32'(hex_ones),   32'(E_SEG_3));
    endtask

    // One full debounced exit: 4 high samples then release
    task automatic do_exit();
        sensor_exit = 1'b1;
        repeat (4) step();
        chk("exit_evt_pulse", 32'(exit_evt), 32'd1);
        sensor_exit = 1'b0;
        step();
        chk("exit_evt_gone", 32'(exit_evt), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        car_admit   = 1'b0;
        sensor_exit = 1'b0;
        repeat (2) step();
        reset = 1'b0;

        // 1: reset state
        chk_reset_vals("rst");

        // 2: fill the lot
        car_admit = 1'b1;
        step();
        chk("adm1_occ",  32'(occupancy), 32'd1);
        chk("adm1_hex",  32'(hex_ones),  32'(E_SEG_3));
        chk("adm1_emp",  32'(lot_empty), 32'd0);
        step();
        chk("adm2_occ",  32'(occupancy), 32'd2);
        chk("adm2_hex",  32'(hex_ones),  32'(E_SEG_2));
        chk("adm2_near", 32'(near_full), 32'(NF_ON));
        step();
        car_admit = 1'b0;
        chk("adm3_occ",  32'(occupancy),  32'd3);
        chk("adm3_free", 32'(free_slots), 32'd0);
        chk("adm3_full", 32'(lot_full),   32'd1);
        chk("adm3_hex",  32'(hex_ones),   32'(E_SEG_1));
        step();
        chk("full_hex0", 32'(hex_ones),   32'(E_SEG_0));
        chk("full_htens", 32'(hex_tens),  32'(E_SEG_BLANK));
        chk("full_err0", 32'(err_flag),   32'd0);

        // 4a: admit together with exit while full
        sensor_exit = 1'b1;
        repeat (3) begin
            step();
            chk("sim_f_noevt", 32'(exit_evt), 32'd0);
        end
        step();
        chk("sim_f_evt", 32'(exit_evt), 32'd1);
        car_admit = 1'b1;
        step();
        car_admit   = 1'b0;
        sensor_exit = 1'b0;
        chk("sim_f_occ", 32'(occupancy), 32'd3);
        chk("sim_f_err", 32'(err_flag),  32'd0);
        chk("sim_f_evt1", 32'(exit_evt), 32'd0);
        step();

        // 3: glitch of 3 highs, then a long 10-cycle assertion
        sensor_exit = 1'b1;
        repeat (3) step();
        sensor_exit = 1'b0;
        step();
        chk("glitch_noevt", 32'(exit_evt), 32'd0);
        chk("glitch_occ",   32'(occupancy), 32'd3);
        sensor_exit = 1'b1;
        evt_cnt     = 0;
        evt_idx     = 0;
        occ_before  = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (exit_evt === 1'b1) begin
                evt_cnt++;
                if (evt_idx == 0) evt_idx = i;
            end
            if (i == 4) occ_before = int'(occupancy);
            if (i == 5) chk("long_occ_dec", 32'(occupancy), 32'd2);
        end
        sensor_exit = 1'b0;
        step();
        chk("long_evt_cnt",  32'(evt_cnt),    32'd1);
        chk("long_evt_idx",  32'(evt_idx),    32'd4);
        chk("long_occ_pre",  32'(occ_before), 32'd3);
        chk("long_occ",      32'(occupancy),  32'd2);
        chk("long_near",     32'(near_full),  32'(NF_ON));
        chk("long_hex",      32'(hex_ones),   32'(E_SEG_1));

        // 6: near_full falls at occupancy 1
        do_exit();
        chk("ex1_occ",  32'(occupancy), 32'd1);
        chk("ex1_near", 32'(near_full), 32'd0);
        do_exit();
        chk("ex0_occ",   32'(occupancy),  32'd0);
        chk("ex0_empty", 32'(lot_empty),  32'd1);
        chk("ex0_free",  32'(free_slots), 32'd3);

        // 4b: admit together with exit while empty
        sensor_exit = 1'b1;
        repeat (4) step();
        chk("sim_e_evt", 32'(exit_evt), 32'd1);
        car_admit = 1'b1;
        step();
        car_admit   = 1'b0;
        sensor_exit = 1'b0;
        chk("sim_e_occ", 32'(occupancy), 32'd0);
        chk("sim_e_err", 32'(err_flag),  32'd0);
        step();

        // 5a: exit from an empty lot is rejected
        do_exit();
        chk("emp_ex_occ", 32'(occupancy), 32'd0);
        chk("emp_ex_err", 32'(err_flag),  32'd1);
        step();
        chk("err_sticky", 32'(err_flag),  32'd1);

        // 5b: reset while in S_CONFIRM
        sensor_exit = 1'b1;
        repeat (2) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_vals("mrst");
        repeat (3) begin
            step();
            chk("mrst_noevt", 32'(exit_evt), 32'd0);
        end
        sensor_exit = 1'b0;
        step();
        chk("mrst_occ", 32'(occupancy), 32'd0);

        // 2b: fourth admit into a full lot
        car_admit = 1'b1;
        repeat (3) step();
        chk("refill_occ", 32'(occupancy), 32'd3);
        chk("refill_err", 32'(err_flag),  32'd0);
        step();
        car_admit = 1'b0;
        chk("over_occ",  32'(occupancy), 32'd3);
        chk("over_err",  32'(err_flag),  32'd1);
        chk("over_full", 32'(lot_full),  32'd1);
        step();
        chk("over_hex",  32'(hex_ones),  32'(E_SEG_0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parking_occupancy_ctrl.md
Name: parking_occupancy_ctrl

Overview:
Downstream stage of the parking gate controller. Consumes the gate's one-cycle "car admitted" pulse and the raw exit sensor, and maintains the lot occupancy count. Drives the lot-full indication back to the gate controller and shows the free-slot count on two 7-segment digits. All outputs are registered.

Parameters:
CAPACITY, 20, number of slots; legal range 1..99.
DEBOUNCE_CYC, 4, consecutive high samples of sensor_exit needed to confirm an exit; legal range 2..255.
CNT_W, 7, width of the occupancy and free counters; must satisfy 2**CNT_W > CAPACITY.

Ports:
clk  in  1  single system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
car_admit  in  1  one-cycle pulse from the gate controller when a car is let in.
sensor_exit  in  1  raw, undebounced exit-lane sensor level.
occupancy  out  CNT_W  cars currently in the lot.
free_slots  out  CNT_W  equals CAPACITY minus occupancy.
lot_full  out  1  high when occupancy equals CAPACITY.
lot_empty  out  1  high when occupancy equals 0.
exit_evt  out  1  one-cycle pulse for each confirmed exit.
err_flag  out  1  sticky; set on a rejected admit or a rejected exit.
near_full  out  1  see Optional Feature.
hex_tens  out  7  tens digit of free_slots, active-low segments, bit0 = a .. bit6 = g.
hex_ones  out  7  ones digit of free_slots, same encoding as hex_tens.

Behaviour:
- Reset values: occupancy 0, free_slots CAPACITY, lot_full 0, lot_empty 1, exit_evt 0, err_flag 0, near_full 0. hex_tens and hex_ones show the digits of CAPACITY. If CAPACITY < 10, hex_tens shows blank (all segments off, 7'h7F).
- Reset asserted mid-operation aborts any debounce in progress and returns the debounce FSM to S_IDLE.
- Exit debounce FSM states: S_IDLE, S_CONFIRM, S_HELD.
  - S_IDLE: when sensor_exit is 1, go to S_CONFIRM with the run counter set to 1.
  - S_CONFIRM: when sensor_exit is 1, increment the run counter. When sensor_exit is 0, return to S_IDLE and clear the counter.
  - S_CONFIRM to S_HELD: taken when the counter equals DEBOUNCE_CYC-1 and sensor_exit is 1 again. exit_evt is registered high for exactly the cycle after that DEBOUNCE_CYC-th consecutive high sample.
  - S_HELD: stays until sensor_exit samples 0, then goes to S_IDLE. Only one exit_evt is produced per sensor assertion, however long it lasts.
- Counter update, one edge after the event (car_admit sample, or exit_evt high):
  - admit only: increment if not full; otherwise count unchanged and err_flag set.
  - exit only: decrement if not empty; otherwise count unchanged and err_flag set.
  - admit and exit in the same cycle: count unchanged, no error, including when full or empty.
- No wrap-around. The count saturates at 0 and at CAPACITY.
- lot_full, lot_empty and free_slots are registered together with occupancy.
- hex_tens and hex_ones are registered one cycle after free_slots. free_slots is split by divide/mod 10 and then passed through the BCD-to-7-segment table.
- err_flag clears only on reset.

Optional Feature:
Macro OCC_NEAR_FULL_EN.
- When defined: adds parameter NEAR_FULL_THRESH (default CAPACITY-2). near_full is registered high while occupancy is at least NEAR_FULL_THRESH, updated in the same cycle as occupancy.
- When not defined: the parameter is absent and near_full is tied to 0. The port list is identical in both builds.

Decomposition:
- Package parking_pkg holds:
  - the exit FSM state enum (S_IDLE, S_CONFIRM, S_HELD);
  - the SEG_0..SEG_9 and SEG_BLANK active-low constants;
  - the seg7_decode function (4-bit BCD in, 7-bit segments out).
- One sub-module is natural: exit_debounce. It holds the FSM and run counter, is parameterised by DEBOUNCE_CYC, takes clk, reset and sensor_exit, and outputs exit_evt.
- The top level keeps the counter, flags and display registers.

Test Plan:
All scenarios use CAPACITY=3 and DEBOUNCE_CYC=4.
1. Release reset -> occupancy 0, free_slots 3, lot_empty 1, hex_tens 7'h7F, hex_ones SEG_3.
2. Three car_admit pulses -> occupancy 3, lot_full 1, hex_ones SEG_0 one cycle after free_slots reaches 0. A fourth admit -> occupancy stays 3 and err_flag becomes 1.
3. sensor_exit high for 3 cycles, low, then high for 10 cycles -> exactly one exit_evt, in the cycle after the 4th consecutive high sample; occupancy drops by 1 on the following edge.
4. With occupancy 3, car_admit in the same cycle as exit_evt -> occupancy stays 3 and err_flag stays 0. Repeat with occupancy 0 -> occupancy stays 0 and no error.
5. With occupancy 0 (lot empty), a confirmed exit -> occupancy stays 0 and err_flag becomes 1. Assert reset while in S_CONFIRM -> FSM back in S_IDLE, all outputs at their reset values, and no exit_evt.
6. OCC_NEAR_FULL_EN defined, NEAR_FULL_THRESH=2 -> near_full rises together with occupancy reaching 2 and falls when occupancy drops to 1. Build without the macro -> near_full stays 0 throughout.
